// File: rtl/lutram_stress_pkg.sv
// Shared types and helpers for the LUTRAM march-test driver.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package lutram_stress_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_BG,
    RD_WR,
    RD_DN,
    DRAIN,
    DONE
  } state_t;

  // Read-then-write sub-cycle used by the ascending read-check/complement pass.
  typedef enum logic {
    SUB_RD,
    SUB_WR
  } sub_t;

  localparam int RD_LAT_MAX = 3;

  // Pattern arithmetic is done at a fixed width and truncated by the caller to DW.
  localparam int PAT_W = 32;

  function automatic logic [PAT_W-1:0] pat(input logic [PAT_W-1:0] a, input logic [PAT_W-1:0] seed);
    return seed ^ a;
  endfunction

endpackage

// File: rtl/lutram_stress_chk.sv
// Read-data checker: delays each issued compare to line up with mem_rdat, counts mismatches.
// Latency: compare retires RD_LAT cycles after issue; err_cnt/first_err_addr update on the following edge.
// Backpressure: none; one compare may be issued every cycle.
module lutram_stress_chk
  import lutram_stress_pkg::*;
#(
  parameter int AW     = 8,
  parameter int DW     = 10,
  parameter int RD_LAT = 0,
  parameter int ERR_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             iss_vld,
  input  logic [AW-1:0]    iss_addr,
  input  logic [DW-1:0]    iss_exp,
  input  logic [DW-1:0]    mem_rdat,
  output logic [ERR_W-1:0] err_cnt,
  output logic [AW-1:0]    first_err_addr
);

  logic          cmp_vld;
  logic [AW-1:0] cmp_addr;
  logic [DW-1:0] cmp_exp;
  logic          mis;

  if (RD_LAT == 0) begin : g_nodly
    assign cmp_vld  = iss_vld;
    assign cmp_addr = iss_addr;
    assign cmp_exp  = iss_exp;
  end else begin : g_dly
    logic [RD_LAT-1:0]         vld_q;
    logic [RD_LAT-1:0][AW-1:0] addr_q;
    logic [RD_LAT-1:0][DW-1:0] exp_q;

    // Shift each compare along so it meets the memory's read data.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_q  <= '0;
        addr_q <= '0;
        exp_q  <= '0;
      end else begin
        vld_q[0]  <= iss_vld;
        addr_q[0] <= iss_addr;
        exp_q[0]  <= iss_exp;
        for (int i = 1; i < RD_LAT; i++) begin
          vld_q[i]  <= vld_q[i-1];
          addr_q[i] <= addr_q[i-1];
          exp_q[i]  <= exp_q[i-1];
        end
      end
    end

    assign cmp_vld  = vld_q[RD_LAT-1];
    assign cmp_addr = addr_q[RD_LAT-1];
    assign cmp_exp  = exp_q[RD_LAT-1];
  end

  assign mis = cmp_vld && (mem_rdat != cmp_exp);

  // Saturating error count; the address is captured only while the count is still zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else if (clr) begin
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else if (mis) begin
      if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
      if (err_cnt == '0) first_err_addr <= cmp_addr;
    end
  end

endmodule

// File: rtl/lutram_stress_driver.sv
// March-test initiator: background write, ascending read/complement-write, descending read; optional LUTRAM_STRESS_ERR_INJECT_EN.
// Latency: done rises 4*DEPTH+RD_LAT+1 edges after the edge that samples start.
// Backpressure: none; start is ignored while busy, the memory is assumed always ready.
module lutram_stress_driver
  import lutram_stress_pkg::*;
#(
  parameter int            DEPTH    = 160,
  parameter int            DW       = 10,
  parameter int            RD_LAT   = 0,
  parameter logic [DW-1:0] SEED     = DW'(10'h2A5),
  parameter int            ERR_W    = 16,
  parameter int            INJ_ADDR = 37,
  localparam int           AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_we,
  output logic [DW-1:0]    mem_wdat,
  input  logic [DW-1:0]    mem_rdat,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [AW-1:0]    first_err_addr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  if (RD_LAT < 0 || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("lutram_stress_driver: RD_LAT out of range");
  end
  if (INJ_ADDR < 0 || INJ_ADDR >= DEPTH) begin : g_bad_inj_addr
    $error("lutram_stress_driver: INJ_ADDR outside the memory");
  end

  state_t        state;
  sub_t          sub;
  logic [1:0]    drain_cnt;
  logic          iss_vld;
  logic [DW-1:0] iss_exp;
  logic          launch;

  function automatic logic [DW-1:0] fwd_pat(input logic [AW-1:0] a);
    return DW'(pat(PAT_W'(a), PAT_W'(SEED)));
  endfunction

  // Background data; the injection variant corrupts bit 0 of one word so a healthy bank must fail.
  function automatic logic [DW-1:0] bg_pat(input logic [AW-1:0] a);
`ifdef LUTRAM_STRESS_ERR_INJECT_EN
    return fwd_pat(a) ^ DW'(a == AW'(INJ_ADDR));
`else
    return fwd_pat(a);
`endif
  endfunction

  assign launch = start && ((state == IDLE) || (state == DONE));
  assign pass   = done && (err_cnt == '0);

  // Sequencer: every memory-side output is registered for the cycle it applies to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sub       <= SUB_RD;
      drain_cnt <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdat  <= '0;
      iss_vld   <= 1'b0;
      iss_exp   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      mem_we  <= 1'b0;
      iss_vld <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= WR_BG;
            mem_addr <= '0;
            mem_we   <= 1'b1;
            mem_wdat <= bg_pat('0);
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end
        WR_BG: begin
          if (mem_addr == LAST) begin
            state    <= RD_WR;
            sub      <= SUB_RD;
            mem_addr <= '0;
            iss_vld  <= 1'b1;
            iss_exp  <= fwd_pat('0);
          end else begin
            mem_addr <= mem_addr + AW'(1);
            mem_we   <= 1'b1;
            mem_wdat <= bg_pat(mem_addr + AW'(1));
          end
        end
        RD_WR: begin
          if (sub == SUB_RD) begin
            sub      <= SUB_WR;
            mem_we   <= 1'b1;
            mem_wdat <= ~fwd_pat(mem_addr);
          end else if (mem_addr == LAST) begin
            // Descending pass starts on the same top word, now holding its complement.
            state   <= RD_DN;
            iss_vld <= 1'b1;
            iss_exp <= ~fwd_pat(LAST);
          end else begin
            sub      <= SUB_RD;
            mem_addr <= mem_addr + AW'(1);
            iss_vld  <= 1'b1;
            iss_exp  <= fwd_pat(mem_addr + AW'(1));
          end
        end
        RD_DN: begin
          if (mem_addr == '0) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end else begin
            mem_addr <= mem_addr - AW'(1);
            iss_vld  <= 1'b1;
            iss_exp  <= ~fwd_pat(mem_addr - AW'(1));
          end
        end
        DRAIN: begin
          if (drain_cnt == 2'(RD_LAT)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  lutram_stress_chk #(
    .AW    (AW),
    .DW    (DW),
    .RD_LAT(RD_LAT),
    .ERR_W (ERR_W)
  ) u_chk (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr           (launch),
    .iss_vld       (iss_vld),
    .iss_addr      (mem_addr),
    .iss_exp       (iss_exp),
    .mem_rdat      (mem_rdat),
    .err_cnt       (err_cnt),
    .first_err_addr(first_err_addr)
  );

endmodule

// File: doc/lutram_stress_driver.md
Name: lutram_stress_driver

Overview:
- Self-contained march-test initiator for the LUTRAM bank: drives `mem_addr`, `mem_we` and `mem_wdat`, and checks the returned `mem_rdat`.
- On a `start` pulse it runs three phases over every word: ascending background write, ascending read-check/complement-write, descending complement read-check.
- It counts mismatches and reports pass/fail, so the bank can be stress-tested on silicon with no external host.

Parameters:
- DEPTH, 160: number of words in the memory under test; need not be a power of two.
- DW, 10: data width.
- RD_LAT, 0: memory read latency in cycles (0 = combinational read); legal range 0..3.
- SEED, 10'h2A5: XOR seed for the data pattern, DW bits.
- ERR_W, 16: error counter width.
- INJ_ADDR, 37: address targeted by optional error injection.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  single-cycle run request
- mem_addr  out  $clog2(DEPTH)  memory address
- mem_we  out  1  memory write enable
- mem_wdat  out  DW  memory write data
- mem_rdat  in  DW  memory read data, valid RD_LAT cycles after mem_addr
- busy  out  1  run in progress
- done  out  1  sticky run-complete flag
- pass  out  1  done && err_cnt==0
- err_cnt  out  ERR_W  saturating mismatch count
- first_err_addr  out  $clog2(DEPTH)  address of first mismatch

Behaviour:
- Reset (rst_n=0 sampled at clk edge): state IDLE; compare pipeline flushed; all outputs 0 (mem_addr, mem_we, mem_wdat, busy, done, pass, err_cnt, first_err_addr).
- Pattern: pat(a) = SEED XOR a (a zero-extended or truncated to DW). Complement is ~pat(a).
- IDLE:
  - start=1 → WR_BG with addr=0; busy=1 from the next cycle.
  - Entering WR_BG clears done, err_cnt and first_err_addr.
- WR_BG: one cycle per address. mem_we=1, mem_wdat=pat(addr), addr ascending 0..DEPTH-1. After DEPTH-1 → RD_WR with addr=0.
- RD_WR: two cycles per address.
  - RD sub-cycle: mem_we=0; issue a compare with expected=pat(addr).
  - WR sub-cycle: mem_we=1, mem_wdat=~pat(addr).
  - After WR at DEPTH-1 → RD_DN with addr=DEPTH-1.
- RD_DN: one cycle per address, descending DEPTH-1..0. mem_we=0; compare with expected=~pat(addr). After addr 0 → DRAIN; no wrap below 0.
- DRAIN: lasts RD_LAT+1 cycles, mem_we=0, so in-flight compares retire. Then → DONE.
- DONE: busy=0, done=1, pass=(err_cnt==0). start=1 re-enters WR_BG.
- Timing: done rises exactly 4*DEPTH+RD_LAT+1 clock edges after the edge that sampled start.
- Compare pipeline:
  - {valid, addr, expected} is delayed RD_LAT stages and compared against mem_rdat.
  - Result is registered one cycle later.
  - On mismatch, err_cnt increments, saturating at 2^ERR_W-1.
  - first_err_addr latches only on the first mismatch of the run.
- start while busy: ignored.
- Reset mid-run: immediate abort to IDLE; done=0; no partial result retained.
- mem_we is never 1 in IDLE, DRAIN or DONE.
- Addresses never exceed DEPTH-1.

Optional Feature:
- Macro: LUTRAM_STRESS_ERR_INJECT_EN.
- Defined: during WR_BG at addr==INJ_ADDR, mem_wdat=pat(INJ_ADDR)^1 (bit 0 flipped). A healthy memory then yields exactly err_cnt=1, first_err_addr=INJ_ADDR, pass=0.
- Undefined: no injection logic is present; mem_wdat always equals the pattern.

Decomposition:
- Package lutram_stress_pkg:
  - state enum {IDLE, WR_BG, RD_WR, RD_DN, DRAIN, DONE};
  - phase sub-cycle typedef;
  - pattern function pat(a, seed);
  - RD_LAT maximum constant.
- Sub-module lutram_stress_chk: holds the compare delay line, comparator, saturating err_cnt and first_err_addr capture. The FSM instantiates it.

Test Plan:
- Ideal combinational memory model, defaults → done at edge 641 after start, pass=1, err_cnt=0, first_err_addr=0.
- Bit 3 of addr 37 stuck at 0:
  - RD_WR expects 0x280 (bit 3 = 0), so no error there.
  - RD_DN expects 0x17F → err_cnt=1, first_err_addr=37, pass=0.
- RD_LAT=2 with registered-read model → pass=1; done at edge 643; mem_we=0 throughout DRAIN.
- ERR_W=4, memory returning constant 0 → err_cnt saturates at 15, first_err_addr=0, pass=0.
- rst_n=0 during RD_WR at addr 80 → next cycle all outputs 0, state IDLE. A subsequent start completes with pass=1. A start pulsed mid-run is ignored, and the done timing is unchanged.
- LUTRAM_STRESS_ERR_INJECT_EN defined, ideal memory → err_cnt=1, first_err_addr=37, pass=0.
